// File: rtl/riscv_pkg.sv
// Shared types for the instruction-memory boot loader: FSM state encoding and word geometry.
package riscv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CHECK,
    RUN,
    ERR
  } loader_state_t;

  localparam int IMEM_WORD_BYTES = 4;

endpackage

// File: rtl/imem_boot_loader_packer.sv
// byte_word_packer: shifts stream bytes into a 32-bit little-endian word and flags the 4th byte.
module byte_word_packer
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  idx_q;
  logic [31:0] word_q;

  // Right-shifting puts the first byte of a group into bits [7:0] after four bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clr_i) begin
      idx_q  <= '0;
    end else if (byte_valid_i) begin
      idx_q  <= idx_q + 2'd1;
      word_q <= {byte_data_i, word_q[31:8]};
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = byte_valid_i && (idx_q == 2'(IMEM_WORD_BYTES - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: fills instruction memory from a byte stream, holding the core in reset until done.
// Optional trailer checksum state enabled by defining LOADER_CHECKSUM_EN.
module imem_boot_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = ADDR_W - 2;
  localparam int N_W   = $clog2(MAX_WORDS + 1);

  loader_state_t    state_q, state_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [N_W-1:0]   n_q, n_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             accept, pack_clr, last_word;
  logic             word_valid;
  logic [31:0]      word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       xor_q, xor_d;
`endif

  assign accept    = in_valid && in_ready;
  assign last_word = (N_W'(word_cnt_q) + N_W'(1)) == n_q;

  byte_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (pack_clr),
    .byte_valid_i (accept && (state_q == DATA)),
    .byte_data_i  (in_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    n_d        = n_q;
    done_d     = done_q;
    error_d    = error_q;
    pack_clr   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    case (state_q)
      IDLE, RUN, ERR: begin
        if (start) begin
          state_d = HDR;
          done_d  = 1'b0;
          error_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      HDR: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          xor_d = xor_q ^ in_data;
`endif
          if (in_data == 8'd0 || int'(in_data) > MAX_WORDS) begin
            state_d = ERR;
            error_d = 1'b1;
          end else begin
            n_d        = N_W'(in_data);
            word_cnt_d = '0;
            pack_clr   = 1'b1;
            state_d    = DATA;
          end
        end
      end
      DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (accept) xor_d = xor_q ^ in_data;
`endif
        if (word_valid) state_d = WRITE;
      end
      WRITE: begin
        word_cnt_d = word_cnt_q + CNT_W'(1);
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = RUN;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          if (in_data == xor_q) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      n_q        <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      n_q        <= n_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) xor_q <= '0;
    else       xor_q <= xor_d;
  end
`endif

  // All outputs decode directly from registered state, so in_ready never depends on in_valid.
  assign in_ready   = (state_q == HDR) || (state_q == DATA) || (state_q == CHECK);
  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = {word_cnt_q, 2'b00};
  assign imem_wdata = word;
  assign core_reset = (state_q != RUN);
  assign busy       = (state_q == HDR) || (state_q == DATA) || (state_q == WRITE) ||
                      (state_q == CHECK);
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes queued at stimulus time, popped by a monitor.
module tb_imem_boot_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 64;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, imem_we, core_reset, busy, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  always #10 clk = ~clk;

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_we = -1;
  int         cr_fall = -1;
  logic       prev_cr = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expected write per imem_we cycle and checks the handshake rule.
  always @(negedge clk) begin
    wr_t w;
    cyc++;
    if (!reset) begin
      chk("in_ready_rule", {31'b0, in_ready}, {31'b0, busy && !imem_we});
      if (imem_we) begin
        last_we = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", imem_addr, imem_wdata);
        end else begin
          w = exp_q.pop_front();
          chk("write_addr", {24'b0, imem_addr}, {24'b0, w.a});
          chk("write_data", imem_wdata, w.d);
        end
      end
      if (prev_cr && !core_reset) cr_fall = cyc;
    end
    prev_cr = core_reset;
  end

  task automatic send_byte(input logic [7:0] b, input int stall);
    int g;
    g = 0;
    in_valid = 1'b0;
    repeat (stall) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready %0b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", {31'b0, busy}, 32'd1);
    chk("start_clears_done", {31'b0, done}, 32'd0);
    chk("start_clears_error", {31'b0, error}, 32'd0);
    chk("start_core_reset", {31'b0, core_reset}, 32'd1);
  endtask

  // fixed=1: stim already holds the data bytes; use_tr=1: send tr_in as trailer instead of the correct one.
  task automatic run_load(input int n, input int smin, input int smax,
                          input bit fixed, input bit use_tr, input logic [7:0] tr_in);
    bit         ok_hdr, ok;
    logic [7:0] ck, tr;
    int         g;
    ok_hdr = (n >= 1) && (n <= MAX_WORDS);
    if (!fixed) begin
      stim.delete();
      if (ok_hdr) for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom_range(0, 255)));
    end
    if (ok_hdr)
      for (int i = 0; i < n; i++)
        exp_q.push_back('{a: ADDR_W'(4 * i),
                          d: {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]}});
    ck = 8'(n);
    foreach (stim[i]) ck = ck ^ stim[i];
    tr = use_tr ? tr_in : ck;
    ok = ok_hdr && (!CK_EN || tr == ck);
    cr_fall = -1;
    do_start();
    send_byte(8'(n), 0);
    if (ok_hdr) begin
      foreach (stim[i]) send_byte(stim[i], $urandom_range(smax, smin));
      if (CK_EN) send_byte(tr, $urandom_range(smax, smin));
    end
    g = 0;
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    chk("load_finishes", {31'b0, busy}, 32'd0);
    chk("writes_outstanding", exp_q.size(), 32'd0);
    exp_q.delete();
    chk("done", {31'b0, done}, {31'b0, ok});
    chk("error", {31'b0, error}, {31'b0, !ok});
    chk("core_reset", {31'b0, core_reset}, {31'b0, !ok});
    if (!CK_EN && ok) chk("core_reset_fall_after_last_write", cr_fall - last_we, 32'd1);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_imem_we", {31'b0, imem_we}, 32'd0);
    chk("rst_imem_addr", {24'b0, imem_addr}, 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_core_reset", {31'b0, core_reset}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    @(negedge clk);

    // Directed two-word program, back to back and then with 3 idle cycles per byte.
    stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 0, 0, 1'b1, 1'b0, 8'h00);
    stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 3, 3, 1'b1, 1'b0, 8'h00);

    // Bytes offered while running must be ignored.
    in_valid = 1'b1;
    repeat (5) begin
      in_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("run_ignores_bytes_done", {31'b0, done}, 32'd1);

    // Bad headers.
    stim.delete(); run_load(0, 0, 0, 1'b1, 1'b0, 8'h00);
    stim.delete(); run_load(65, 0, 0, 1'b1, 1'b0, 8'h00);
    stim.delete(); run_load(200, 0, 0, 1'b1, 1'b0, 8'h00);

    // Full-capacity image and random-size images with random stalls.
    run_load(MAX_WORDS, 0, 2, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) run_load($urandom_range(1, 12), 0, 4, 1'b0, 1'b0, 8'h00);

    // Reset in the middle of the second word.
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom_range(0, 255)));
    exp_q.push_back('{a: '0, d: {stim[3], stim[2], stim[1], stim[0]}});
    do_start();
    send_byte(8'd2, 0);
    for (int i = 0; i < 6; i++) send_byte(stim[i], $urandom_range(2, 0));
    reset = 1'b1;
    #2;
    check_reset_values();
    chk("reset_midload_writes_seen", exp_q.size(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_load(3, 0, 1, 1'b0, 1'b0, 8'h00);

    if (CK_EN) begin
      stim = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_load(1, 0, 1, 1'b1, 1'b1, 8'h05);
      stim = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_load(1, 0, 1, 1'b1, 1'b1, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
